uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter with an input FIFO. Accepts bytes from the puzzle core over the `en`/`busy` handshake and serialises them as 8N1 frames (8E1 when parity is compiled in) on the board's TX pin. It sits directly downstream of the puzzle core's `output_en`/`output_data`/`output_busy` port. The FIFO lets the core emit a whole hex word without stalling on every byte.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit, for example 12 MHz / 115200. Must be ≥ 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tx_en` in 1: upstream presents a byte this cycle.
- `tx_data` in 8: byte to send; sampled when `tx_en && !tx_busy`.
- `tx_busy` out 1: FIFO full; a byte presented now is not accepted.
- `tx` out 1: serial line; idles high.
- `tx_idle` out 1: high when the FIFO is empty and no frame is in progress.
- `overrun` out 1: sticky flag, set when `tx_en` is high while `tx_busy` is high. Cleared only by `rst`.

## Operation

- **Push:** on a rising edge with `tx_en && !tx_busy`, `tx_data` is written at the write pointer and the count increments.
- **Rejected push:** if `tx_en` is high while `tx_busy` is high, the byte is dropped and `overrun` is set.
- **`tx_busy` source:** a registered `count == FIFO_DEPTH`. A pop in the same cycle does not make room for a push in that cycle.
- **Pointers and count:** pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo depth. The count is `$clog2(FIFO_DEPTH)+1` bits wide. A simultaneous push and pop leaves the count unchanged.
- **Shifter FSM:** states IDLE → START → DATA → (PARITY) → STOP.
  - IDLE: `tx`=1. If count > 0, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index selects the bit.
  - PARITY: present only with the macro.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On its last cycle: if count > 0, pop and go directly to START, with no idle bit between frames; otherwise go to IDLE.
- **Baud counter:** `$clog2(CLKS_PER_BIT)` bits wide. Reloads to 0 on every state or bit change. A bit ends when the counter equals CLKS_PER_BIT-1.
- **`tx` register:** `tx` is driven from a register, so no combinational glitches appear on the pin.
- **`tx_idle`:** equals (state == IDLE) && (count == 0), registered.

## Timing

- **Reset values:** `tx`=1, `tx_busy`=0, `tx_idle`=1, `overrun`=0. FIFO empty, FSM in IDLE.
- **Reset mid-frame:** the frame is aborted, `tx` is high on the next cycle, and queued bytes are discarded.
- **Latency:** a byte is accepted at edge E into an empty FIFO with IDLE state. At E+1 the FSM pops it. `tx` falls after E+2 (the registered output) and stays low for exactly CLKS_PER_BIT cycles.
- **Frame length:** 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- **`tx_busy` timing:** asserts the cycle after the push that fills the FIFO. It deasserts the cycle after the first subsequent pop.
- **Upstream compatibility:** the upstream block treats `!tx_busy` as acceptance in the same cycle, so `tx_busy` must never be low in a cycle where the push would be refused.

## Configuration

- **`UART_TX_PARITY_EN`:**
  - Defined: a PARITY state follows bit 7 and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frames are 8E1.
  - Undefined: the PARITY state and parity logic are absent. Frames are 8N1.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- **Single byte:** push 0x41 once → `tx` sequence, 4 cycles per bit: 0,1,0,0,0,0,0,1,0,1. Then `tx_idle`=1 exactly 40 cycles after the start bit begins.
- **Fill and overrun:** hold `tx_en` high with 0x30–0x37 on consecutive cycles, ignoring `tx_busy` → `tx_busy` rises once the FIFO is full. Only accepted bytes appear on `tx`, in order, in back-to-back frames with no idle bit. `overrun`=1.
- **Upstream-style burst:** push "0000002a" (8 bytes) only while `!tx_busy` → all 8 bytes are received by a bench UART decoder. `overrun` stays 0.
- **Parity (macro defined):** 0x07 → parity bit 1. 0x03 → parity bit 0. Each frame is 44 cycles.
- **Reset mid-frame:** assert `rst` during data bit 3 of a frame with 2 bytes queued → `tx`=1, `tx_idle`=1, `tx_busy`=0 the next cycle. No further frames are sent.
- **Wrap-around:** push 10 bytes spaced to keep the FIFO non-full → pointers wrap twice and all 10 bytes are transmitted in order.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: FIFO-buffered 8N1 serialiser with registered TX pin.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_idle,
  output logic       overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  // Shifter
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          idle_q, idle_d;

  logic push, pop, bit_done, have_data;

  assign push      = tx_en && !busy_q;
  assign bit_done  = (baud_q == BAUD_LAST);
  assign have_data = (count_q != '0);

  // Next-state for the shifter; pop happens on entry to START.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (have_data) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin value follows the current state, one cycle behind the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    idle_d = (state_q == S_IDLE) && (count_q == '0);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Registered full flag: a same-cycle pop never frees a slot for a push.
    busy_d    = (count_d == DEPTH_C);
    overrun_d = overrun_q | (tx_en & busy_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      tx_q      <= 1'b1;
      idle_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      idle_q    <= idle_d;
    end
  end

  assign tx_busy = busy_q;
  assign tx      = tx_q;
  assign tx_idle = idle_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed steps, byte scoreboard and a serial-line decoder.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx, tx_idle, overrun;

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;
  int gap = 0;
  logic [7:0] sb [$];
  int         gaps_q [$];
  logic       par_q [$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx(tx), .tx_idle(tx_idle), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; waits for room, presents one byte for one edge.
  task automatic push_hs(input logic [7:0] b);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("push_wait", n, 0);
    tx_en = 1'b1; tx_data = b; sb.push_back(b);
    @(negedge clk);
    tx_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || tx_idle !== 1'b1) && n < 4000) begin @(negedge clk); n++; end
    check(tag, (n < 4000), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Line decoder: every bit must hold for exactly CPB samples.
  logic       smp [NB*CPB];
  logic       aborted, ok;
  logic [7:0] rx_byte, exp_b;
  initial begin : decoder
    forever begin
      @(negedge clk);
      if (rst || tx !== 1'b0) begin
        gap++;
      end else begin
        aborted = 1'b0;
        smp[0] = tx;
        for (int i = 1; i < NB*CPB; i++) begin
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          smp[i] = tx;
        end
        if (!aborted) begin
          ok = 1'b1;
          for (int b = 0; b < NB; b++)
            for (int c = 1; c < CPB; c++)
              if (smp[CPB*b+c] !== smp[CPB*b]) ok = 1'b0;
          if (smp[CPB*(NB-1)] !== 1'b1) ok = 1'b0;
          for (int k = 0; k < 8; k++) rx_byte[k] = smp[CPB*(k+1)];
`ifdef UART_TX_PARITY_EN
          if (smp[CPB*9] !== ^rx_byte) ok = 1'b0;
          par_q.push_back(smp[CPB*9]);
`endif
          check("frame_shape", ok, 1);
          check("frame_expected", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            check("rx_byte", rx_byte, exp_b);
          end
          gaps_q.push_back(gap);
          frames++;
        end
        gap = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int    n, f0, zeros;
  string s;
  logic [7:0] rb;
  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte and first-frame latency
    push_hs(8'h41);
    check("lat_tx_e1", tx, 1);
    @(negedge clk);
    check("lat_tx_e2", tx, 1);
    check("idle_drop", tx_idle, 0);
    @(negedge clk);
    check("start_bit", tx, 0);
    n = 0;
    while (tx_idle !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("idle_after_frame", n, NB*CPB);
    drain("drain_single");

    // Fill and overrun: 8 consecutive presents, only 0x30..0x34 fit
    gaps_q.delete(); f0 = frames;
    for (int i = 0; i < 5; i++) sb.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      tx_en = 1'b1; tx_data = 8'h30 + 8'(i);
      if (i == 4) check("busy_before_full", tx_busy, 0);
      if (i == 5) check("busy_full", tx_busy, 1);
      @(negedge clk);
    end
    tx_en = 1'b0;
    check("overrun_set", overrun, 1);
    drain("drain_fill");
    check("fill_frames", frames - f0, 5);
    if (gaps_q.size() == 5)
      for (int i = 1; i < 5; i++) check("b2b_gap", gaps_q[i], 0);

    // Upstream-style burst honouring tx_busy
    do_reset();
    f0 = frames;
    s = "0000002a";
    for (int i = 0; i < 8; i++) push_hs(s[i]);
    drain("drain_burst");
    check("burst_frames", frames - f0, 8);
    check("burst_no_overrun", overrun, 0);

`ifdef UART_TX_PARITY_EN
    par_q.delete(); gaps_q.delete();
    push_hs(8'h07);
    push_hs(8'h03);
    drain("drain_parity");
    check("parity_cnt", par_q.size(), 2);
    if (par_q.size() == 2) begin
      check("parity_07", par_q[0], 1);
      check("parity_03", par_q[1], 0);
    end
    if (gaps_q.size() == 2) check("parity_b2b", gaps_q[1], 0);
`endif

    // Wrap-around: 10 spaced pushes through a 4-deep FIFO
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      push_hs(rb);
      repeat (28) @(negedge clk);
    end
    drain("drain_wrap");
    check("wrap_frames", frames - f0, 10);
    check("wrap_no_overrun", overrun, 0);

    // Reset during data bit 3 with two bytes queued
    push_hs(8'hA5);
    push_hs(8'h5A);
    push_hs(8'hC3);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("midrst_start_seen", (n < 100), 1);
    repeat (4*CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_idle", tx_idle, 1);
    check("midrst_busy", tx_busy, 0);
    rst = 1'b0;
    sb.delete();
    f0 = frames; zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("midrst_line_quiet", zeros, 0);
    check("midrst_no_frames", frames - f0, 0);
    check("midrst_still_idle", tx_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
